spi_slave_regfile: RTL
======================

Name: spi_slave_regfile

Overview:
SPI slave register file that sits directly downstream of the team's APB SPI master and consumes the frames that master produces on sclk/mosi. Each frame is an 8-bit address byte sent LSB-first, where bit7=1 means write and bit7=0 means read, followed by an 8-bit data byte. The block oversamples the SPI pins on the local clock, stores write data, and returns read data on miso. A local host port preloads registers and observes committed writes.

Parameters:
DEPTH, 8, number of 8-bit registers; valid index range 0..DEPTH-1.
WIDTH, 8, byte width; fixed at 8, and the bit counters assume 8.
TIMEOUT, 64, pclk_i cycles without an sclk edge mid-byte before abort (used only with the optional feature).

Ports:
pclk_i  input  1  local clock; must be at least 8x the sclk frequency.
prst_i  input  1  reset.
sclk_i  input  1  SPI clock from the master; idles high.
mosi_i  input  1  serial data from the master; changes on sclk rising edge.
cs_i  input  1  active-high slave select.
miso_o  output  1  serial data to the master.
ld_en_i  input  1  host preload strobe.
ld_addr_i  input  $clog2(DEPTH)  host preload index.
ld_data_i  input  WIDTH  host preload data.
rx_valid_o  output  1  one-cycle pulse when an SPI write commits.
rx_addr_o  output  7  index of the committed write (addr byte bits [6:0]).
rx_data_o  output  WIDTH  data of the committed write.
busy_o  output  1  high while in ADDR with bits received, or in DATA.
err_o  output  1  one-cycle pulse on an out-of-range index.

Behaviour:
- Clocking and reset: one clock, pclk_i; reset prst_i is synchronous, active-high.
- Reset values: miso_o=1, rx_valid_o=0, rx_addr_o=0, rx_data_o=0, busy_o=0, err_o=0; all registers=0; state=IDLE; bit counter=0.
- Synchronisers: sclk_i, mosi_i and cs_i each pass through a 2-flop synchroniser.
- Edge detect: compare the synchronised sclk against a delayed copy to find falling and rising edges.
- Sampling: mosi is sampled on each detected sclk falling edge, mid-bit relative to the master's rising-edge launch. Bits shift in LSB-first, so bit n lands in shift[n].
- State IDLE: miso_o=1. Go to ADDR when synchronised cs=1.
- State ADDR:
  - Each falling edge samples one bit and increments the counter.
  - On the 8th bit, latch addr[7:0] and clear the counter, then go to DATA.
  - If the latched addr is a read (bit7=0), load tx_shift: reg[addr[6:0]] when addr[6:0]<DEPTH, else 8'hFF with err_o pulsed. Drive miso_o=tx_shift[0] in the same cycle.
- State DATA:
  - Each falling edge samples one mosi bit into rx_shift.
  - On reads, each falling edge after the first advances miso_o to the next tx_shift bit. miso_o is therefore stable at every sclk rising edge, which is where the master samples.
  - On the 8th bit of a write: if index<DEPTH, write reg[index]=rx_shift and pulse rx_valid_o with rx_addr_o/rx_data_o one cycle after the edge is detected. If index>=DEPTH, do not write and pulse err_o.
  - After the 8th bit, miso_o=1, then go to ADDR. Back-to-back frames separated by sclk-high gaps are supported without any cs toggle.
- Gaps: sclk held high between bytes generates no edges. Counters hold their value and there is no timeout unless the optional feature is compiled in.
- Deselect: synchronised cs=0 in any state means go to IDLE next cycle, clear the counter, set miso_o=1, and commit nothing. A partial byte is discarded.
- Preload: ld_en_i writes reg[ld_addr_i]=ld_data_i when ld_addr_i<DEPTH. If it hits the same index as a committing SPI write in the same cycle, the SPI write wins.
- Read snapshot: a read snapshots the register at address completion. A later preload does not alter bits already in flight.
- Reset mid-frame: reset returns to reset values immediately; the frame is lost.

Optional Feature:
SPI_SLV_TIMEOUT_EN:
- Defined: a counter runs whenever the block is in ADDR or DATA with counter>0, and clears on every sclk edge. Reaching TIMEOUT discards the partial byte, clears the counter, pulses err_o and goes to ADDR; miso_o=1.
- Undefined: there is no timeout logic, and partial bytes persist until cs=0 or reset.

Test Plan:
1. Write frame: addr 8'h83, then data 8'hA5, both LSB-first → reg[3]=8'hA5; rx_valid_o one pulse with rx_addr_o=3, rx_data_o=8'hA5; err_o=0.
2. Read frame: preload reg[5]=8'h3C via ld_en_i, then send addr 8'h05 and 8 data clocks → miso_o sampled at rising edges gives 0,0,1,1,1,1,0,0 (8'h3C LSB-first); rx_valid_o stays 0.
3. Out-of-range: with DEPTH=8, send addr 8'h8A and data 8'h11 → no register changes, err_o pulses, rx_valid_o=0. Then addr 8'h0A as a read → miso_o returns 8'hFF.
4. Back-to-back: write reg[0]=8'h01 and reg[1]=8'h02 with a 4-sclk-high gap between frames and cs held high → two rx_valid_o pulses and both registers updated.
5. Abort: deassert cs_i after 3 address bits, reassert, then send a full write of addr 8'h82, data 8'h77 → reg[2]=8'h77 and no stale bits.
6. Collision and reset: ld_en_i to index 3 in the same cycle as an SPI commit to index 3 → SPI data kept. Reset asserted mid-DATA → all outputs return to reset values and all registers read 0.

Source files
------------

// File: rtl/spi_slave_regfile.sv
// rtl/spi_slave_regfile.sv - SPI slave register file fed by LSB-first addr/data frames, with host preload port
// Optional feature macro: SPI_SLV_TIMEOUT_EN (abort a stalled partial byte after TIMEOUT pclk_i cycles)
module spi_slave_regfile #(
    parameter int DEPTH   = 8,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                     pclk_i,
    input  logic                     prst_i,
    input  logic                     sclk_i,
    input  logic                     mosi_i,
    input  logic                     cs_i,
    output logic                     miso_o,
    input  logic                     ld_en_i,
    input  logic [$clog2(DEPTH)-1:0] ld_addr_i,
    input  logic [WIDTH-1:0]         ld_data_i,
    output logic                     rx_valid_o,
    output logic [6:0]               rx_addr_o,
    output logic [WIDTH-1:0]         rx_data_o,
    output logic                     busy_o,
    output logic                     err_o
);

    localparam int AW = $clog2(DEPTH);

    if (WIDTH != 8) begin : g_width_chk
        $error("spi_slave_regfile: WIDTH must be 8");
    end
    if (TIMEOUT < 2) begin : g_timeout_chk
        $error("spi_slave_regfile: TIMEOUT must be at least 2");
    end

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

    state_t           state_q, state_d;
    logic             sclk_meta_q, sclk_sync_q, sclk_dly_q;
    logic             mosi_meta_q, mosi_sync_q;
    logic             cs_meta_q, cs_sync_q;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic             miso_q, miso_d;
    logic             rx_valid_q, rx_valid_d;
    logic [6:0]       rx_addr_q, rx_addr_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];

    logic             sclk_fall, sclk_rise;
    logic [WIDTH-1:0] shift_bit;
    logic [6:0]       rd_idx, wr_idx;
    logic             rd_hit, wr_hit;
    logic [WIDTH-1:0] rd_byte;

`ifdef SPI_SLV_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] to_cnt_q, to_cnt_d;
`endif

    assign sclk_fall = sclk_dly_q & ~sclk_sync_q;
    assign sclk_rise = ~sclk_dly_q & sclk_sync_q;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        addr_d     = addr_q;
        miso_d     = miso_q;
        rx_valid_d = 1'b0;
        rx_addr_d  = rx_addr_q;
        rx_data_d  = rx_data_q;
        err_d      = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
        end

        // The byte as it stands once the bit sampled on this edge is inserted.
        shift_bit            = rx_shift_q;
        shift_bit[bit_cnt_q] = mosi_sync_q;

        rd_idx  = shift_bit[6:0];
        rd_hit  = 32'(rd_idx) < DEPTH;
        rd_byte = rd_hit ? regs_q[rd_idx[AW-1:0]] : 8'hFF;
        wr_idx  = addr_q[6:0];
        wr_hit  = 32'(wr_idx) < DEPTH;

        if (ld_en_i && (32'(ld_addr_i) < DEPTH)) begin
            regs_d[ld_addr_i] = ld_data_i;
        end

        if (!cs_sync_q) begin
            state_d   = S_IDLE;
            bit_cnt_d = 3'd0;
            miso_d    = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d   = S_ADDR;
                    bit_cnt_d = 3'd0;
                    miso_d    = 1'b1;
                end
                S_ADDR: begin
                    if (sclk_fall) begin
                        rx_shift_d = shift_bit;
                        if (bit_cnt_q == 3'd7) begin
                            addr_d    = shift_bit;
                            bit_cnt_d = 3'd0;
                            state_d   = S_DATA;
                            if (!shift_bit[7]) begin
                                tx_shift_d = rd_byte;
                                miso_d     = rd_byte[0];
                                err_d      = ~rd_hit;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end else if (sclk_rise) begin
                        // Last read bit was held through the master's closing rising edge; release the line now.
                        miso_d = 1'b1;
                    end
                end
                S_DATA: begin
                    if (sclk_fall) begin
                        rx_shift_d = shift_bit;
                        if (!addr_q[7] && (bit_cnt_q != 3'd0)) begin
                            tx_shift_d = {tx_shift_q[0], tx_shift_q[WIDTH-1:1]};
                            miso_d     = tx_shift_q[1];
                        end
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d = 3'd0;
                            state_d   = S_ADDR;
                            if (addr_q[7]) begin
                                if (wr_hit) begin
                                    regs_d[wr_idx[AW-1:0]] = shift_bit;
                                    rx_valid_d = 1'b1;
                                    rx_addr_d  = wr_idx;
                                    rx_data_d  = shift_bit;
                                end else begin
                                    err_d = 1'b1;
                                end
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

`ifdef SPI_SLV_TIMEOUT_EN
        to_cnt_d = '0;
        if (cs_sync_q && (state_q != S_IDLE) && (bit_cnt_q != 3'd0) && !sclk_fall && !sclk_rise) begin
            if (to_cnt_q == TW'(TIMEOUT - 1)) begin
                bit_cnt_d = 3'd0;
                state_d   = S_ADDR;
                miso_d    = 1'b1;
                err_d     = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
`endif

        busy_d = (state_d == S_DATA) || ((state_d == S_ADDR) && (bit_cnt_d != 3'd0));
    end

    always_ff @(posedge pclk_i) begin
        if (prst_i) begin
            sclk_meta_q <= 1'b1;
            sclk_sync_q <= 1'b1;
            sclk_dly_q  <= 1'b1;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
            cs_meta_q   <= 1'b0;
            cs_sync_q   <= 1'b0;
            state_q     <= S_IDLE;
            bit_cnt_q   <= 3'd0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            addr_q      <= '0;
            miso_q      <= 1'b1;
            rx_valid_q  <= 1'b0;
            rx_addr_q   <= '0;
            rx_data_q   <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
`ifdef SPI_SLV_TIMEOUT_EN
            to_cnt_q    <= '0;
`endif
        end else begin
            sclk_meta_q <= sclk_i;
            sclk_sync_q <= sclk_meta_q;
            sclk_dly_q  <= sclk_sync_q;
            mosi_meta_q <= mosi_i;
            mosi_sync_q <= mosi_meta_q;
            cs_meta_q   <= cs_i;
            cs_sync_q   <= cs_meta_q;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            addr_q      <= addr_d;
            miso_q      <= miso_d;
            rx_valid_q  <= rx_valid_d;
            rx_addr_q   <= rx_addr_d;
            rx_data_q   <= rx_data_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
`ifdef SPI_SLV_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
`endif
        end
    end

    assign miso_o     = miso_q;
    assign rx_valid_o = rx_valid_q;
    assign rx_addr_o  = rx_addr_q;
    assign rx_data_o  = rx_data_q;
    assign busy_o     = busy_q;
    assign err_o      = err_q;

endmodule
